// File: rtl/logic_result_collector.sv
// Collects the selected logical-unit result into a small FIFO with zero/parity tags.
// Illegal selects (6,7) are consumed without storing and flagged by a one-cycle err pulse.
module logic_result_collector #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               Y0,
    input  logic [7:0]               Y1,
    input  logic [7:0]               Y2,
    input  logic [7:0]               Y3,
    input  logic [7:0]               Y4,
    input  logic [7:0]               Y5,
    input  logic [2:0]               op,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [2:0]               out_op,
    output logic                     out_zero,
    output logic                     out_parity,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] op;
        logic       zero;
        logic       parity;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;

    logic [7:0]      sel;
    logic            legal, accept, push, pop;
    entry_t          head;

    always_comb begin
        sel = 8'h00;
        case (op)
            3'd0:    sel = Y0;
            3'd1:    sel = Y1;
            3'd2:    sel = Y2;
            3'd3:    sel = Y3;
            3'd4:    sel = Y4;
            3'd5:    sel = Y5;
            default: sel = 8'h00;
        endcase
    end

    // Handshake signals derive only from registered occupancy, so no
    // combinational path crosses from out_ready or in_valid to the other side.
    assign legal     = (op <= 3'd5);
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        err_d    = accept && !legal;
        if (push) begin
            mem_d[wr_ptr_q] = '{data: sel, op: op, zero: (sel == 8'h00), parity: ^sel};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            mem_q    <= mem_d;
        end
    end

    // Head fields are forced to zero while empty so stale slots never leak out.
    assign head       = mem_q[rd_ptr_q];
    assign out_data   = out_valid ? head.data   : 8'h00;
    assign out_op     = out_valid ? head.op     : 3'd0;
    assign out_zero   = out_valid ? head.zero   : 1'b0;
    assign out_parity = out_valid ? head.parity : 1'b0;
    assign err        = err_q;
    assign count      = count_q;
endmodule

// File: doc/logic_result_collector.md
LOGIC_RESULT_COLLECTOR -- requirements
Module: logic_result_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the result FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have ports Y0,Y1,Y2,Y3,Y4,Y5, input, 8 bits each: logical-unit result buses AND, OR, NAND, NOR, XOR, XNOR.
REQ-005 The block SHALL have port op, input, 3 bits: result select (0=Y0 ... 5=Y5; 6,7 illegal).
REQ-006 The block SHALL have port in_valid, input, 1 bit: op and Y buses are valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: collector can accept a request this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: FIFO head entry is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream consumes head entry this cycle.
REQ-010 The block SHALL have port out_data, output, 8 bits: selected result of the head entry.
REQ-011 The block SHALL have port out_op, output, 3 bits: op recorded with the head entry.
REQ-012 The block SHALL have port out_zero, output, 1 bit: head out_data equals 0x00.
REQ-013 The block SHALL have port out_parity, output, 1 bit: XOR reduction of head out_data.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse on acceptance of an illegal op.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-016 Accept SHALL occur when in_valid and in_ready are both 1 on a rising clk edge.
REQ-017 in_ready SHALL equal 1 exactly when count < DEPTH; it SHALL not depend on out_ready (no full-bypass).
REQ-018 On accepting a legal op, the block SHALL write {Y[op], op, zero, parity} into the FIFO tail, with zero/parity computed from Y[op] at accept time.
REQ-019 On accepting an illegal op (6 or 7), the block SHALL write nothing, leave count unchanged, and assert err for exactly the next cycle.
REQ-020 Pop SHALL occur when out_valid and out_ready are both 1 on a rising clk edge; the head advances by one entry.
REQ-021 out_valid SHALL equal 1 exactly when count > 0; out_data/out_op/out_zero/out_parity SHALL show the head entry whenever out_valid is 1 and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Latency SHALL be one cycle: an entry accepted at edge N SHALL be visible with out_valid=1 after edge N when the FIFO was empty.
REQ-023 Simultaneous legal push and pop in the same edge SHALL leave count unchanged and preserve FIFO order.
REQ-024 Simultaneous illegal-op accept and pop SHALL decrement count by one and pulse err.
REQ-025 out_ready while out_valid=0 SHALL have no effect; in_valid while in_ready=0 SHALL have no effect and SHALL not pulse err.
REQ-026 Read and write pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated entries.
REQ-027 count SHALL stay within 0..DEPTH under all input sequences.
REQ-028 The block SHALL contain no combinational path from out_ready to in_ready, nor from in_valid to out_valid.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL set count=0, pointers=0, err=0, out_valid=0, in_ready=1 after that edge, with out_data, out_op, out_zero, out_parity all 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries and any pending err pulse; accepts and pops SHALL be ignored on reset edges.
REQ-031 The first accept SHALL be possible on the first edge with rst=0.

Verification
REQ-032 Reset then op=0, Y0=0x30, one-cycle in_valid, out_ready=1 -> next cycle out_valid=1, out_data=0x30, out_op=0, out_zero=0, out_parity=0; popped following edge, count returns 0.
REQ-033 op=3, Y3=0x00 -> out_data=0x00, out_zero=1, out_parity=0; op=4, Y4=0x07 -> out_data=0x07, out_zero=0, out_parity=1.
REQ-034 out_ready=0, DEPTH=4, five back-to-back accepts with ops 0..4 -> in_ready=0 after fourth accept, fifth held off, count=4; then out_ready=1 drains ops 0,1,2,3 in order, then op 4 accepted.
REQ-035 Continuous push+pop at full throughput for 3*DEPTH cycles with incrementing Y values -> count constant, outputs in order across pointer wrap, no drops.
REQ-036 op=6 accepted with in_valid=1 -> err=1 for exactly one cycle, count unchanged, no output entry; op=7 with in_ready=0 -> no err.
REQ-037 Fill to count=3, assert rst for one cycle -> count=0, out_valid=0, in_ready=1, err=0; subsequent accept behaves as post-reset.
